pwm_decoder: RTL and testbench

PWM_DECODER -- requirements
Module: pwm_decoder

---
 rtl/pwm_decoder.sv | 237 +++++++++++++++++++++++
 tb/tb_pwm_decoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures the high time and period of an asynchronous PWM
// input in units of step ticks and reports them once per rising edge.
//
// Ports:
//   clk     in   single clock for all state
//   rst     in   asynchronous active-high reset
//   ena     in   measurement enable; low returns the block to IDLE
//   step    in   sample strobe; the input is sampled only on step cycles
//   in      in   PWM waveform, asynchronous to clk
//   duty    out  [N-1:0] high time of the last completed period
//   period  out  [N:0]   length of the last completed period (0 = timeout)
//   valid   out  one-clk pulse whenever duty/period/stuck are updated
//   stuck   out  1 when the last report was a no-edge timeout
//
// Operation:
//   The input is brought into the clk domain with a 2-flop synchronizer.
//   The state machine waits in ARM for the first rising edge, then counts
//   step ticks (per_cnt) and high ticks (hi_cnt) in MEASURE.  Each later
//   rising edge reports the finished period and restarts the counters at 1,
//   since the rising sample itself is the first tick of the new period.
//   If per_cnt reaches its all-ones value without a rising edge, a stuck
//   report is issued instead and the block re-arms.

module pwm_decoder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         step,
    input  logic         in,
    output logic [N-1:0] duty,
    output logic [N:0]   period,
    output logic         valid,
    output logic         stuck
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    // Counter limits: per_cnt times out at all-ones, duty saturates at 2^N-1.
    localparam logic [N:0] CNT_MAX  = {(N+1){1'b1}};
    localparam logic [N:0] CNT_ONE  = {{N{1'b0}}, 1'b1};
    localparam logic [N:0] DUTY_MAX = {1'b0, {N{1'b1}}};

    state_t state;
    state_t state_nxt;

    // Synchronizer and its priming flags.
    logic sync1;
    logic sync2;
    logic prime1;
    logic prime2;

    // Edge detection and counters.
    logic       prev;
    logic       prev_nxt;
    logic [N:0] per_cnt;
    logic [N:0] per_nxt;
    logic [N:0] hi_cnt;
    logic [N:0] hi_nxt;

    logic sample;
    logic tick;
    logic rise;
    logic at_max;

    // Report request computed from the current step cycle.
    logic         rpt;
    logic [N-1:0] rpt_duty;
    logic [N:0]   rpt_period;
    logic         rpt_stuck;

    // ------------------------------------------------------------------
    // Input synchronizer.
    // The synchronizer flops clear to 0 on reset, so for the first two
    // clocks afterwards sync2 does not reflect the pin.  prime1/prime2
    // track that window; without it a waveform that is high across reset
    // would show a fake 0->1 transition and produce a partial period.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prime1 <= 1'b0;
            prime2 <= 1'b0;
        end else begin
            sync1  <= in;
            sync2  <= sync1;
            prime1 <= 1'b1;
            prime2 <= prime1;
        end
    end

    assign sample = sync2;

    // A step cycle only counts once armed; step in IDLE is ignored.
    assign tick   = ena & step & prime2 & (state != IDLE);
    assign rise   = ~prev & sample;
    assign at_max = (per_cnt == CNT_MAX);

    // ------------------------------------------------------------------
    // FSM state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic.  ena low overrides everything, which also
    // drops any report that would have been issued in that cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (!ena) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = ARM;
                end
                ARM: begin
                    if (tick && rise) begin
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    if (tick && !rise && at_max) begin
                        state_nxt = ARM;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM output logic: decide whether this step cycle produces a report.
    // A rising edge in ARM only starts the first period, so it reports
    // nothing.  A timeout reports the level the input is stuck at.
    // ------------------------------------------------------------------
    always_comb begin
        rpt        = 1'b0;
        rpt_duty   = '0;
        rpt_period = '0;
        rpt_stuck  = 1'b0;
        if (tick) begin
            if (rise) begin
                if (state == MEASURE) begin
                    rpt        = 1'b1;
                    rpt_period = per_cnt;
                    if (hi_cnt > DUTY_MAX) begin
                        rpt_duty = {N{1'b1}};
                    end else begin
                        rpt_duty = hi_cnt[N-1:0];
                    end
                end
            end else if (at_max) begin
                rpt       = 1'b1;
                rpt_duty  = {N{sample}};
                rpt_stuck = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Counter and edge-history next values.
    // prev is held at 1 while disabled so that a waveform already high
    // at enable is not mistaken for a rising edge.
    // hi_cnt only advances in MEASURE; in ARM it stays at zero.
    // ------------------------------------------------------------------
    always_comb begin
        per_nxt  = per_cnt;
        hi_nxt   = hi_cnt;
        prev_nxt = prev;
        if (!ena) begin
            per_nxt  = '0;
            hi_nxt   = '0;
            prev_nxt = 1'b1;
        end else if (tick) begin
            prev_nxt = sample;
            if (rise) begin
                per_nxt = CNT_ONE;
                hi_nxt  = CNT_ONE;
            end else if (at_max) begin
                per_nxt = '0;
                hi_nxt  = '0;
            end else begin
                per_nxt = per_cnt + CNT_ONE;
                if (state == MEASURE) begin
                    hi_nxt = hi_cnt + {{N{1'b0}}, sample};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters, edge history and result registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
            prev    <= 1'b1;
        end else begin
            per_cnt <= per_nxt;
            hi_cnt  <= hi_nxt;
            prev    <= prev_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty   <= '0;
            period <= '0;
            stuck  <= 1'b0;
            valid  <= 1'b0;
        end else begin
            valid <= rpt;
            if (rpt) begin
                duty   <= rpt_duty;
                period <= rpt_period;
                stuck  <= rpt_stuck;
            end
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: directed stimulus for pwm_decoder with a queue-based
// reference model compared every clock, plus literal report checks.

module tb_pwm_decoder;

    localparam int N = 8;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         ena  = 1'b0;
    logic         step = 1'b0;
    logic         in   = 1'b0;
    logic [N-1:0] duty;
    logic [N:0]   period;
    logic         valid;
    logic         stuck;

    int checks = 0;
    int errors = 0;
    int shown  = 0;
    int dvalid = 0;

    pwm_decoder #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .step   (step),
        .in     (in),
        .duty   (duty),
        .period (period),
        .valid  (valid),
        .stuck  (stuck)
    );

    always #5 clk = ~clk;

    // Reference model.  hist holds every sample taken since the current
    // period started (or since the last clear while waiting for an edge);
    // a report's period is its length and its duty the number of ones.
    bit           ms1;
    bit           ms2;
    bit           mprev;
    int           mode;
    int           warm;
    bit           hist[$];
    logic [N-1:0] exp_duty   = '0;
    logic [N:0]   exp_period = '0;
    logic         exp_stuck  = 1'b0;
    logic         exp_valid  = 1'b0;
    int           rq_duty[$];
    int           rq_period[$];
    int           rq_stuck[$];

    task automatic report(input int d, input int p, input int s);
        exp_duty   = N'(d);
        exp_period = (N+1)'(p);
        exp_stuck  = s[0];
        exp_valid  = 1'b1;
        rq_duty.push_back(d);
        rq_period.push_back(p);
        rq_stuck.push_back(s);
    endtask

    always @(posedge clk) begin
        bit smp;
        bit primed;
        bit rise;
        int hs;
        exp_valid = 1'b0;
        if (rst) begin
            exp_duty   = '0;
            exp_period = '0;
            exp_stuck  = 1'b0;
            ms1   = 1'b0;
            ms2   = 1'b0;
            mprev = 1'b1;
            mode  = 0;
            warm  = 0;
            hist.delete();
        end else begin
            smp    = ms2;
            ms2    = ms1;
            ms1    = in;
            primed = (warm >= 2);
            if (warm < 2) warm++;
            if (!ena) begin
                mode  = 0;
                mprev = 1'b1;
                hist.delete();
            end else if (mode == 0) begin
                mode = 1;
            end else if (step && primed) begin
                rise  = !mprev && smp;
                mprev = smp;
                if (rise) begin
                    if (mode == 2) begin
                        hs = 0;
                        foreach (hist[i]) hs += int'(hist[i]);
                        report((hs > 255) ? 255 : hs, hist.size(), 0);
                    end
                    mode = 2;
                    hist.delete();
                    hist.push_back(1'b1);
                end else if (hist.size() == 511) begin
                    report(smp ? 255 : 0, 0, 1);
                    mode = 1;
                    hist.delete();
                end else begin
                    hist.push_back(smp);
                end
            end
        end
        #1;
        if (valid === 1'b1) dvalid++;
        checks++;
        if (duty !== exp_duty || period !== exp_period ||
            stuck !== exp_stuck || valid !== exp_valid) begin
            errors++;
            if (shown < 20) begin
                shown++;
                $display("FAIL cycle t=%0t duty got %0d want %0d period got %0d want %0d stuck got %0b want %0b valid got %0b want %0b",
                         $time, duty, exp_duty, period, exp_period,
                         stuck, exp_stuck, valid, exp_valid);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    // One step tick lasts div clocks with step high on the first one.
    task automatic drive(input bit v, input int n, input int div);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < div; c++) begin
                @(negedge clk);
                in   = v;
                step = (c == 0);
            end
        end
    endtask

    task automatic chk_rep(input string nm, input int idx,
                           input int d, input int p, input int s);
        if (idx < rq_duty.size()) begin
            chk({nm, "_duty"}, rq_duty[idx], d);
            chk({nm, "_period"}, rq_period[idx], p);
            chk({nm, "_stuck"}, rq_stuck[idx], s);
        end else begin
            chk({nm, "_present"}, 0, 1);
        end
    endtask

    initial begin
        int b;
        int d;

        repeat (3) @(negedge clk);
        chk("rst_duty", int'(duty), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_stuck", int'(stuck), 0);
        rst = 1'b0;

        // 64 high / 192 low, step every clock.
        ena = 1'b1;
        b = rq_duty.size();
        d = dvalid;
        drive(0, 5, 1);
        repeat (4) begin
            drive(1, 64, 1);
            drive(0, 192, 1);
        end
        drive(1, 5, 1);
        chk("a_reports", rq_duty.size() - b, 4);
        chk("a_dut_valids", dvalid - d, 4);
        chk_rep("a_first", b, 64, 256, 0);
        chk_rep("a_last", b + 3, 64, 256, 0);

        // Input held low: repeated stuck-low timeouts; step ignored while disabled.
        ena = 1'b0;
        drive(0, 4, 1);
        ena = 1'b1;
        b = rq_duty.size();
        drive(0, 1100, 1);
        chk("b_reports", rq_duty.size() - b, 2);
        chk_rep("b_first", b, 0, 0, 1);
        chk_rep("b_second", b + 1, 0, 0, 1);

        // Input already high at enable: no edge, stuck-high report.
        ena = 1'b0;
        drive(1, 4, 1);
        ena = 1'b1;
        b = rq_duty.size();
        drive(1, 600, 1);
        chk("c_reports", rq_duty.size() - b, 1);
        chk_rep("c_first", b, 255, 0, 1);

        // Step every 4th clock, 10 high / 20 low ticks.
        ena = 1'b0;
        drive(0, 4, 1);
        ena = 1'b1;
        b = rq_duty.size();
        d = dvalid;
        drive(0, 3, 4);
        repeat (4) begin
            drive(1, 10, 4);
            drive(0, 20, 4);
        end
        drive(1, 3, 4);
        chk("d_reports", rq_duty.size() - b, 4);
        chk("d_dut_valids", dvalid - d, 4);
        chk_rep("d_first", b, 10, 30, 0);
        chk_rep("d_last", b + 3, 10, 30, 0);

        // Reset in the middle of a high phase.
        drive(0, 192, 1);
        drive(1, 30, 1);
        @(negedge clk);
        rst  = 1'b1;
        in   = 1'b1;
        step = 1'b1;
        #1;
        chk("e_rst_duty", int'(duty), 0);
        chk("e_rst_period", int'(period), 0);
        chk("e_rst_valid", int'(valid), 0);
        chk("e_rst_stuck", int'(stuck), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        b = rq_duty.size();
        drive(1, 34, 1);
        drive(0, 192, 1);
        drive(1, 64, 1);
        drive(0, 192, 1);
        drive(1, 5, 1);
        chk("e_reports", rq_duty.size() - b, 1);
        chk_rep("e_first", b, 64, 256, 0);

        // ena dropped for 5 clocks in the low phase.
        drive(1, 59, 1);
        drive(0, 100, 1);
        b = rq_duty.size();
        d = dvalid;
        ena = 1'b0;
        drive(0, 5, 1);
        chk("f_gap_reports", rq_duty.size() - b, 0);
        chk("f_gap_valids", dvalid - d, 0);
        ena = 1'b1;
        b = rq_duty.size();
        drive(0, 92, 1);
        drive(1, 64, 1);
        drive(0, 192, 1);
        drive(1, 5, 1);
        chk("f_reports", rq_duty.size() - b, 1);
        chk_rep("f_first", b, 64, 256, 0);

        @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
